spi_ram_ctrl: RTL
=================

Name: spi_ram_ctrl

Overview:
Single-lane SPI master that sequences one 32-bit word access to an external SPI SRAM (READ 0x03 / WRITE 0x02, 24-bit address). Sits between the OBI-side SPI RAM shim (word request, data, clock-divider config) and the chip pins. Generates SCK, CS_n and MOSI, samples MISO, and returns one response pulse per granted request. One transaction in flight; no queuing.

Parameters:
AddrBytes, 3, number of address bytes sent after the command
DivWidth, 5, width of SCK low/high divider inputs
CmdRead, 8'h03, command byte for reads
CmdWrite, 8'h02, command byte for writes

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  word request valid (held until gnt_o)
gnt_o  out  1  request accepted this cycle
we_i  in  1  1 = write, 0 = read
addr_i  in  8*AddrBytes  byte address; bits [1:0] ignored (sent as 0)
wdata_i  in  32  write data
clk_div_lo_i  in  DivWidth  SCK low phase = value+1 cycles
clk_div_hi_i  in  DivWidth  SCK high phase = value+1 cycles
rsp_valid_o  out  1  one-cycle completion pulse (read and write)
rdata_o  out  32  read data, valid with rsp_valid_o; 0 for writes
busy_o  out  1  high whenever state != IDLE
spi_sck_o  out  1  SPI clock, mode 0 (idle low)
spi_cs_no  out  1  chip select, active low
spi_mosi_o  out  1  serial out
spi_miso_i  in  1  serial in

Behaviour:
- Reset: cs_n=1, sck=0, mosi=0, rsp_valid=0, rdata=0, busy=0, state IDLE. Reset mid-transfer aborts immediately (cs_n high asynchronously); no response issued.
- gnt_o = req_i && state==IDLE (combinational). On grant latch we_i, addr_i, wdata_i, both dividers; later input changes ignored until next grant.
- Frame: NBits = 8 + 8*AddrBytes + 32 (64 default). Order: command byte, address bytes MSB-byte first, then data bytes lowest byte first (wdata[7:0] first); every byte MSB-first. Read data phase: mosi=0.
- Read capture: first data byte received -> rdata[7:0], 4th -> rdata[31:24]; MISO during command/address ignored.
- Bit timing: per bit, low phase (lo+1 cycles) then high phase (hi+1 cycles). MOSI updates at start of low phase; MISO sampled on the clock edge that drives sck 0->1.
- FSM: IDLE -> CS_SETUP (1 cycle, cs_n=0, sck=0) -> SHIFT (NBits*(lo+hi+2) cycles) -> CS_HOLD (1 cycle, sck=0, cs_n=0) -> RESP (1 cycle, cs_n=1, rsp_valid=1, rdata valid) -> IDLE.
- Latency: grant in cycle 0 -> rsp_valid in cycle 3+N, N=NBits*(lo+hi+2); next grant earliest cycle 4+N (RESP doubles as minimum CS deselect). Default divider 0/0: rsp at cycle 131.
- rdata_o holds last read value until next read response; writes drive 0 during their RESP cycle.
- Counters: bit counter 0..NBits-1, phase counter DivWidth bits, no wrap beyond terminal count.

Decomposition:
- spi_ram_pkg: state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, RESP), command constants, NBits function.
- Sub-module spi_ram_clkgen: phase counter producing sck, rise/fall strobes from latched lo/hi; FSM/shift registers stay in spi_ram_ctrl.

Test Plan:
- Write 32'hDEADBEEF to 0x000104, div 0/0 -> MOSI bytes 02 00 01 04 EF BE AD DE, 128 SCK cycles, rsp_valid in cycle 131, rdata 0.
- Read 0x000200, MISO model returns 11 22 33 44 in data phase -> MOSI 03 00 02 00 then zeros; rdata 32'h44332211 with rsp_valid.
- Divider lo=3, hi=1 -> SCK low 4/high 2 cycles, rsp_valid in cycle 387; changing dividers mid-transfer has no effect.
- req_i held high for two reads -> second gnt exactly cycle 4+N after first; cs_n high for at least 1 cycle between frames.
- Address 0x000107 -> address bytes 00 01 04 (low bits cleared).
- Assert rst_ni low mid-SHIFT -> cs_n=1, sck=0 same cycle, no rsp_valid; next request after reset completes normally.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and helpers for the SPI SRAM word-access controller.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    RESP
  } state_e;

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam int unsigned DATA_BITS = 32;

  // Total serial bits per frame: command, address, one data word.
  function automatic int unsigned nbits(input int unsigned addr_bytes);
    return 8 + 8 * addr_bytes + DATA_BITS;
  endfunction

  // Reverse byte order so the lowest byte travels first on the wire.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_ram_clkgen.sv
// SCK phase generator: low phase of lo+1 cycles, then high phase of hi+1
// cycles, repeating while enabled. Strobes mark the cycle before each edge.
module spi_ram_clkgen
  import spi_ram_pkg::*;
#(
  parameter int unsigned DivWidth = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [DivWidth-1:0] div_lo_i,
  input  logic [DivWidth-1:0] div_hi_i,
  output logic                sck_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic [DivWidth-1:0] cnt_q;
  logic                high_q;
  logic                phase_end;

  // Terminal count of the current phase and the edge strobes it implies.
  always_comb begin
    phase_end = high_q ? (cnt_q == div_hi_i) : (cnt_q == div_lo_i);
    rise_o    = en_i && !high_q && phase_end;
    fall_o    = en_i &&  high_q && phase_end;
    sck_o     = high_q;
  end

  // Phase counter; parks in the low phase with a cleared count when disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else if (phase_end) begin
      cnt_q  <= '0;
      high_q <= !high_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Single-lane SPI master performing one 32-bit word read or write to an
// external SPI SRAM per granted request.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned AddrBytes = 3,
  parameter int unsigned DivWidth  = 5,
  parameter logic [7:0]  CmdRead   = CMD_READ,
  parameter logic [7:0]  CmdWrite  = CMD_WRITE
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [8*AddrBytes-1:0] addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [DivWidth-1:0]    clk_div_lo_i,
  input  logic [DivWidth-1:0]    clk_div_hi_i,
  output logic                   rsp_valid_o,
  output logic [31:0]            rdata_o,
  output logic                   busy_o,
  output logic                   spi_sck_o,
  output logic                   spi_cs_no,
  output logic                   spi_mosi_o,
  input  logic                   spi_miso_i
);

  localparam int unsigned AddrW = 8 * AddrBytes;
  localparam int unsigned NBits = nbits(AddrBytes);
  localparam int unsigned CntW  = $clog2(NBits);
  localparam logic [CntW-1:0] LastBit   = CntW'(NBits - 1);
  localparam logic [CntW-1:0] DataStart = CntW'(NBits - DATA_BITS);

  state_e              state_q, state_d;
  logic                we_q;
  logic [DivWidth-1:0] lo_q, hi_q;
  logic [NBits-1:0]    tx_q, frame;
  logic [31:0]         rx_q, rdata_q;
  logic [CntW-1:0]     bit_q;
  logic                sck_en, rise, fall;

  spi_ram_clkgen #(
    .DivWidth (DivWidth)
  ) u_clkgen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (sck_en),
    .div_lo_i (lo_q),
    .div_hi_i (hi_q),
    .sck_o    (spi_sck_o),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  // Outgoing frame: command, word-aligned address, data low byte first.
  always_comb begin
    frame = {we_i ? CmdWrite : CmdRead,
             addr_i & ~AddrW'(3),
             we_i ? bswap32(wdata_i) : 32'h0};
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: one frame per grant, RESP doubles as CS deselect time.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_i) state_d = CS_SETUP;
      CS_SETUP: state_d = SHIFT;
      SHIFT:    if (fall && bit_q == LastBit) state_d = CS_HOLD;
      CS_HOLD:  state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; all pin outputs fall back to idle on reset.
  always_comb begin
    gnt_o       = req_i && (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    spi_cs_no   = !(state_q inside {CS_SETUP, SHIFT, CS_HOLD});
    sck_en      = (state_q == SHIFT);
    rsp_valid_o = (state_q == RESP);
    spi_mosi_o  = (state_q inside {CS_SETUP, SHIFT}) ? tx_q[NBits-1] : 1'b0;
    rdata_o     = (state_q == RESP && we_q) ? 32'h0 : rdata_q;
  end

  // Request capture, serial shifting and read-data assembly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
    end else begin
      if (gnt_o) begin
        we_q  <= we_i;
        lo_q  <= clk_div_lo_i;
        hi_q  <= clk_div_hi_i;
        tx_q  <= frame;
        bit_q <= '0;
      end
      if (state_q == SHIFT) begin
        if (rise && bit_q >= DataStart) rx_q <= {rx_q[30:0], spi_miso_i};
        if (fall) begin
          tx_q <= tx_q << 1;
          if (bit_q != LastBit) bit_q <= bit_q + 1'b1;
        end
      end
      // rx_q holds bytes in arrival order; first byte becomes rdata[7:0].
      if (state_q == CS_HOLD && !we_q) rdata_q <= bswap32(rx_q);
    end
  end

endmodule
